// File: rtl/gray_pkg.sv
// Shared helpers for the 4-bit offset-Gray link decoder.
// Reflected-Gray conversion, popcount and a bitwise majority vote.
package gray_pkg;

    localparam int GRAY_W = 4;

    function automatic logic [GRAY_W-1:0] gray2bin4(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [GRAY_W-1:0] bin2gray4(input logic [GRAY_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [2:0] popcount4(input logic [GRAY_W-1:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [GRAY_W-1:0] vote4(
        input logic [GRAY_W-1:0] a,
        input logic [GRAY_W-1:0] b,
        input logic [GRAY_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/cb4gray_dec_if.sv
// Link bundle between a cb4gray consumer and the decoder.
// master = environment side, slave = decoder side.
interface cb4gray_dec_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       GRAY_IN;
    logic             EN;
    logic             CLR;
    logic [3:0]       BIN;
    logic             STEP;
    logic             ERR;
    logic             ERR_STICKY;
    logic [CNT_W-1:0] CNT;

    modport master (
        output GRAY_IN, EN, CLR,
        input  BIN, STEP, ERR, ERR_STICKY, CNT
    );

    modport slave (
        input  GRAY_IN, EN, CLR,
        output BIN, STEP, ERR, ERR_STICKY, CNT
    );
endinterface

// File: rtl/cb4gray_sync.sv
// SYNC-deep 4-bit synchroniser with synchronous reset.
// CB4GRAY_DEC_TMR_EN: each stage triplicated, next stage fed from the voted copy.
module cb4gray_sync
    import gray_pkg::*;
#(
    parameter int SYNC = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [GRAY_W-1:0] i_d,
    output logic [GRAY_W-1:0] o_q
);

`ifdef CB4GRAY_DEC_TMR_EN
    (* ASYNC_REG = "TRUE", syn_keep = 1 *)
    logic [GRAY_W-1:0] r_stg [3][SYNC];
    logic [GRAY_W-1:0] w_v [SYNC];

    always_comb begin
        for (int i = 0; i < SYNC; i++) begin
            w_v[i] = vote4(r_stg[0][i], r_stg[1][i], r_stg[2][i]);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 3; k++) begin
            if (i_rst) begin
                for (int i = 0; i < SYNC; i++) r_stg[k][i] <= '0;
            end else begin
                r_stg[k][0] <= i_d;
                for (int i = 1; i < SYNC; i++) r_stg[k][i] <= w_v[i-1];
            end
        end
    end

    assign o_q = w_v[SYNC-1];
`else
    (* ASYNC_REG = "TRUE" *)
    logic [GRAY_W-1:0] r_stg [SYNC];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC; i++) r_stg[i] <= '0;
        end else begin
            r_stg[0] <= i_d;
            for (int i = 1; i < SYNC; i++) r_stg[i] <= r_stg[i-1];
        end
    end

    assign o_q = r_stg[SYNC-1];
`endif

endmodule

// File: rtl/cb4gray_dec.sv
// Receive-side decoder for the cb4gray offset-Gray count.
// CB4GRAY_DEC_TMR_EN: triplicates prev_g, BIN, CNT and ERR_STICKY.
module cb4gray_dec
    import gray_pkg::*;
#(
    parameter int SYNC  = 2,
    parameter int CNT_W = 16
) (
    input  logic         CLK,
    input  logic         RST,
    cb4gray_dec_if.slave bus
);

    logic [GRAY_W-1:0] w_s;
    logic [GRAY_W-1:0] w_bin_q, w_prev_q, w_bin_n, w_d;
    logic [CNT_W-1:0]  w_cnt_q, w_cnt_n;
    logic              w_sticky_q, w_sticky_n;
    logic [2:0]        w_hd;
    logic              w_fwd, w_step, w_err;
    logic              r_step, r_err;

    cb4gray_sync #(.SYNC(SYNC)) u_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (bus.GRAY_IN),
        .o_q   (w_s)
    );

    // Any change that is not exactly one forward step is an error.
    always_comb begin
        w_bin_n    = gray2bin4(w_s);
        w_d        = w_bin_n - w_bin_q;
        w_hd       = popcount4(w_s ^ w_prev_q);
        w_fwd      = (w_hd == 3'd1) && (w_d == 4'd1);
        w_step     = bus.EN && w_fwd;
        w_err      = bus.EN && (w_hd != 3'd0) && !w_fwd;
        w_cnt_n    = bus.CLR ? CNT_W'(w_step) : w_cnt_q + CNT_W'(w_step);
        w_sticky_n = bus.CLR ? w_err : (w_sticky_q | w_err);
    end

`ifdef CB4GRAY_DEC_TMR_EN
    (* syn_keep = 1 *) logic [GRAY_W-1:0] r_bin    [3];
    (* syn_keep = 1 *) logic [GRAY_W-1:0] r_prev   [3];
    (* syn_keep = 1 *) logic [CNT_W-1:0]  r_cnt    [3];
    (* syn_keep = 1 *) logic              r_sticky [3];

    assign w_bin_q    = vote4(r_bin[0], r_bin[1], r_bin[2]);
    assign w_prev_q   = vote4(r_prev[0], r_prev[1], r_prev[2]);
    assign w_cnt_q    = (r_cnt[0] & r_cnt[1]) | (r_cnt[0] & r_cnt[2])
                      | (r_cnt[1] & r_cnt[2]);
    assign w_sticky_q = (r_sticky[0] & r_sticky[1]) | (r_sticky[0] & r_sticky[2])
                      | (r_sticky[1] & r_sticky[2]);

    always_ff @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (RST) begin
                r_bin[k]    <= '0;
                r_prev[k]   <= '0;
                r_cnt[k]    <= '0;
                r_sticky[k] <= 1'b0;
            end else begin
                r_bin[k]    <= w_bin_n;
                r_prev[k]   <= w_s;
                r_cnt[k]    <= w_cnt_n;
                r_sticky[k] <= w_sticky_n;
            end
        end
    end
`else
    logic [GRAY_W-1:0] r_bin, r_prev;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_sticky;

    assign w_bin_q    = r_bin;
    assign w_prev_q   = r_prev;
    assign w_cnt_q    = r_cnt;
    assign w_sticky_q = r_sticky;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_bin    <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            r_bin    <= w_bin_n;
            r_prev   <= w_s;
            r_cnt    <= w_cnt_n;
            r_sticky <= w_sticky_n;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_step <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_step <= w_step;
            r_err  <= w_err;
        end
    end

    assign bus.BIN        = w_bin_q;
    assign bus.STEP       = r_step;
    assign bus.ERR        = r_err;
    assign bus.ERR_STICKY = w_sticky_q;
    assign bus.CNT        = w_cnt_q;

endmodule

// File: tb/tb_cb4gray_dec.sv
// Scoreboard bench for cb4gray_dec: directed link scenarios then random traffic.
// Expected outputs come from a count-level model of the decoder behaviour.
module tb_cb4gray_dec;

    localparam int SYNC  = 3;
    localparam int CNT_W = 6;

    typedef struct {
        int bin;
        bit step;
        bit err;
        bit sticky;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    cb4gray_dec_if #(.CNT_W(CNT_W)) bus ();

    cb4gray_dec #(.SYNC(SYNC), .CNT_W(CNT_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q [$];

    // Model state: sampled-value delay line plus decoder observables.
    int m_pipe [$];
    int m_prev, m_bin, m_cnt;
    bit m_sticky;
    int src;

    function automatic int g2b(input int g);
        return (g ^ (g >> 1) ^ (g >> 2) ^ (g >> 3)) & 15;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic tick(input int g, input bit en, input bit clr, input bit r);
        exp_t e;
        int   s, nb, d, hd;
        bit   fwd, st, er;
        @(negedge clk);
        bus.GRAY_IN = 4'(g);
        bus.EN      = en;
        bus.CLR     = clr;
        rst         = r;
        if (r) begin
            m_pipe.delete();
            for (int i = 0; i < SYNC; i++) m_pipe.push_back(0);
            m_prev = 0; m_bin = 0; m_cnt = 0; m_sticky = 0;
            e = '{bin: 0, step: 0, err: 0, sticky: 0, cnt: 0};
        end else begin
            s  = m_pipe.pop_front();
            m_pipe.push_back(g);
            nb  = g2b(s);
            d   = (nb - m_bin + 16) % 16;
            hd  = $countones(s ^ m_prev);
            fwd = (hd == 1) && (d == 1);
            st  = en && fwd;
            er  = en && (hd != 0) && !fwd;
            m_cnt    = clr ? int'(st) : (m_cnt + int'(st)) % (1 << CNT_W);
            m_sticky = clr ? er : (m_sticky | er);
            m_bin    = nb;
            m_prev   = s;
            e = '{bin: nb, step: st, err: er, sticky: m_sticky, cnt: m_cnt};
        end
        exp_q.push_back(e);
    endtask

    task automatic hold(input int n, input bit en);
        repeat (n) tick(b2g(src), en, 1'b0, 1'b0);
    endtask

    task automatic set_gray(input int g, input int n);
        src = g2b(g);
        repeat (n) tick(g, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: the DUT presents a new output set every cycle.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("BIN",        32'(bus.BIN),        32'(e.bin));
            chk("STEP",       32'(bus.STEP),       32'(e.step));
            chk("ERR",        32'(bus.ERR),        32'(e.err));
            chk("ERR_STICKY", 32'(bus.ERR_STICKY), 32'(e.sticky));
            chk("CNT",        32'(bus.CNT),        32'(e.cnt));
        end
    end

    initial begin
        int r;
        bus.GRAY_IN = '0;
        bus.EN      = 1'b1;
        bus.CLR     = 1'b0;
        src         = 0;
        repeat (3) tick(0, 1'b1, 1'b0, 1'b1);

        // 20 source pulses, one every 4 clocks, wrapping 15->0
        for (int p = 0; p < 20; p++) begin
            src = (src + 1) % 16;
            hold(4, 1'b1);
        end
        hold(SYNC + 3, 1'b1);

        // 1 -> 3 jump, then backward 2 -> 1, then clear
        set_gray(4'b0001, 8);
        set_gray(4'b0010, 8);
        set_gray(4'b0011, 8);
        set_gray(4'b0001, 8);
        tick(4'b0001, 1'b1, 1'b1, 1'b0);
        hold(4, 1'b1);

        // EN low across three steps, then re-enable
        for (int p = 0; p < 3; p++) begin
            src = (src + 1) % 16;
            hold(4, 1'b0);
        end
        hold(6, 1'b1);

        // CLR landing on the cycle a step is classified
        src = (src + 1) % 16;
        hold(SYNC, 1'b1);
        tick(b2g(src), 1'b1, 1'b1, 1'b0);
        hold(4, 1'b1);

        // Build CNT=7 with sticky set, then reset mid-run
        for (int p = 0; p < 6; p++) begin
            src = (src + 1) % 16;
            hold(3, 1'b1);
        end
        set_gray(b2g((src + 2) % 16), 6);
        tick(b2g(src), 1'b1, 1'b0, 1'b1);
        src = 0;
        hold(4, 1'b1);

        // Random traffic, long enough to wrap the 6-bit counter
        for (int c = 0; c < 3000; c++) begin
            bit en, clr, rs;
            int g;
            r = int'($urandom_range(0, 99));
            if (r < 45)      src = (src + 1) % 16;
            else if (r < 49) src = int'($urandom_range(0, 15));
            g   = b2g(src);
            en  = ($urandom_range(0, 99) < 90);
            clr = ($urandom_range(0, 99) < 2);
            rs  = ($urandom_range(0, 999) < 4);
            if (rs) src = 0;
            tick(rs ? 0 : g, en, clr, rs);
        end

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
